// File: rtl/riscv_mmio_pkg.sv
// Shared constants and types for the MMIO UART peripheral.
// Register offsets are word indices taken from mem_addr[3:2].
package riscv_mmio_pkg;

  localparam logic [1:0] TXDATA_OFF  = 2'd0;
  localparam logic [1:0] STATUS_OFF  = 2'd1;
  localparam logic [1:0] BAUDDIV_OFF = 2'd2;

  localparam int ST_BUSY   = 0;
  localparam int ST_FULL   = 1;
  localparam int ST_EMPTY  = 2;
  localparam int ST_OVF    = 3;
  localparam int ST_CNT_LO = 4;
  localparam int ST_CNT_HI = 7;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } uart_tx_state_t;

endpackage

// File: rtl/riscv_mmio_uart_tx_fifo.sv
// Synchronous FIFO with occupancy count; push is dropped when full,
// with full judged before any pop on the same edge.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_full,
  output logic             o_empty,
  output logic [CW-1:0]    o_count
);

  localparam logic [AW-1:0] PTR_ONE = 1;
  localparam logic [CW-1:0] CNT_ONE = 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [CW-1:0]    r_count;
  logic             w_push_ok;
  logic             w_pop_ok;

  assign o_full    = (r_count == CW'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_rdata   = r_mem[r_rptr];
  assign w_push_ok = i_push && !o_full;
  assign w_pop_ok  = i_pop && !o_empty;

  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wptr] <= i_wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push_ok) r_wptr <= r_wptr + PTR_ONE;
      if (w_pop_ok)  r_rptr <= r_rptr + PTR_ONE;
      unique case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/riscv_mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter for the single-cycle core.
// Bytes queue in a FIFO; the FSM streams frames back to back.
module riscv_mmio_uart_tx
  import riscv_mmio_pkg::*;
#(
  parameter int FIFO_DEPTH  = 8,
  parameter int DEFAULT_DIV = 868,
  parameter int DIV_W       = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_we,
  input  logic        mem_re,
  input  logic [3:0]  mem_addr,
  input  logic [31:0] mem_wdata,
  output logic [31:0] mem_rdata,
  output logic        tx,
  output logic        irq
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [DIV_W-1:0] ONE = 1;

  logic [1:0]       w_sel;
  logic             w_wr_tx;
  logic             w_wr_st;
  logic             w_wr_div;
  logic [DIV_W-1:0] w_div_in;
  logic [DIV_W-1:0] r_div;
  logic             r_ovf;

  logic             w_full;
  logic             w_empty;
  logic [CW-1:0]    w_count;
  logic [7:0]       w_fifo_data;
  logic [3:0]       w_cnt_sat;
  logic [31:0]      w_status;

  uart_tx_state_t   r_state;
  uart_tx_state_t   w_state_d;
  logic [DIV_W-1:0] r_baud;
  logic [DIV_W-1:0] w_baud_d;
  logic [2:0]       r_bit;
  logic [2:0]       w_bit_d;
  logic [7:0]       r_shift;
  logic [7:0]       w_shift_d;
  logic             r_tx;
  logic             w_tx_d;
  logic             w_bit_end;
  logic             w_pop;
  logic             w_unused;

  assign w_sel    = mem_addr[3:2];
  assign w_wr_tx  = mem_we && (w_sel == TXDATA_OFF);
  assign w_wr_st  = mem_we && (w_sel == STATUS_OFF);
  assign w_wr_div = mem_we && (w_sel == BAUDDIV_OFF);
  assign w_div_in = mem_wdata[DIV_W-1:0];
  assign w_unused = ^{mem_addr[1:0], mem_wdata};

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_wr_tx),
    .i_wdata (mem_wdata[7:0]),
    .i_pop   (w_pop),
    .o_rdata (w_fifo_data),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  // A zero divisor would stall the baud counter, so it is stored as 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div <= DIV_W'(DEFAULT_DIV);
      r_ovf <= 1'b0;
    end else begin
      if (w_wr_div) r_div <= (w_div_in == '0) ? ONE : w_div_in;
      if (w_wr_tx && w_full) begin
        r_ovf <= 1'b1;
      end else if (w_wr_st && mem_wdata[ST_OVF]) begin
        r_ovf <= 1'b0;
      end
    end
  end

  always_comb begin
    w_cnt_sat = 4'(w_count);
    if (32'(w_count) > 32'd15) w_cnt_sat = 4'hF;
  end

  always_comb begin
    w_status                      = '0;
    w_status[ST_BUSY]             = (r_state != IDLE);
    w_status[ST_FULL]             = w_full;
    w_status[ST_EMPTY]            = w_empty;
    w_status[ST_OVF]              = r_ovf;
    w_status[ST_CNT_HI:ST_CNT_LO] = w_cnt_sat;
  end

  always_comb begin
    mem_rdata = '0;
    if (mem_re) begin
      case (w_sel)
        STATUS_OFF:  mem_rdata = w_status;
        BAUDDIV_OFF: mem_rdata = 32'(r_div);
        default:     mem_rdata = '0;
      endcase
    end
  end

  assign w_bit_end = (r_baud == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_baud  <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_tx    <= 1'b1;
    end else begin
      r_state <= w_state_d;
      r_baud  <= w_baud_d;
      r_bit   <= w_bit_d;
      r_shift <= w_shift_d;
      r_tx    <= w_tx_d;
    end
  end

  always_comb begin
    w_state_d = r_state;
    w_pop     = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (!w_empty) begin
          w_pop     = 1'b1;
          w_state_d = START;
        end
      end
      START: begin
        if (w_bit_end) w_state_d = DATA;
      end
      DATA: begin
        if (w_bit_end && (r_bit == 3'd7)) w_state_d = STOP;
      end
      STOP: begin
        if (w_bit_end) begin
          if (!w_empty) begin
            w_pop     = 1'b1;
            w_state_d = START;
          end else begin
            w_state_d = IDLE;
          end
        end
      end
      default: w_state_d = IDLE;
    endcase
  end

  // The divisor is resampled at every bit boundary.
  always_comb begin
    w_tx_d    = r_tx;
    w_baud_d  = r_baud;
    w_bit_d   = r_bit;
    w_shift_d = r_shift;
    if (w_pop) begin
      w_shift_d = w_fifo_data;
      w_tx_d    = 1'b0;
      w_baud_d  = r_div - ONE;
      w_bit_d   = '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          w_tx_d = 1'b1;
        end
        START: begin
          if (w_bit_end) begin
            w_tx_d   = r_shift[0];
            w_baud_d = r_div - ONE;
          end else begin
            w_baud_d = r_baud - ONE;
          end
        end
        DATA: begin
          if (w_bit_end) begin
            w_baud_d = r_div - ONE;
            if (r_bit == 3'd7) begin
              w_tx_d = 1'b1;
            end else begin
              w_bit_d   = r_bit + 3'd1;
              w_shift_d = r_shift >> 1;
              w_tx_d    = r_shift[1];
            end
          end else begin
            w_baud_d = r_baud - ONE;
          end
        end
        STOP: begin
          w_tx_d = 1'b1;
          if (!w_bit_end) w_baud_d = r_baud - ONE;
        end
        default: w_tx_d = 1'b1;
      endcase
    end
  end

  assign tx  = r_tx;
  assign irq = (r_state == IDLE) && w_empty;

endmodule

// File: tb/tb_riscv_mmio_uart_tx.sv
// Directed bench for riscv_mmio_uart_tx: register table plus
// frame-timing, back-to-back, overflow and mid-frame reset sequences.
module tb_riscv_mmio_uart_tx;

  logic        clk;
  logic        rst_n;
  logic        mem_we;
  logic        mem_re;
  logic [3:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        tx;
  logic        irq;

  int n_checks;
  int n_err;

  typedef struct {
    logic        we;
    logic        re;
    logic [3:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp;
    string       name;
  } vec_t;

  vec_t tbl[15];

  riscv_mmio_uart_tx #(
    .FIFO_DEPTH  (8),
    .DEFAULT_DIV (868),
    .DIV_W       (16)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .mem_we    (mem_we),
    .mem_re    (mem_re),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .tx        (tx),
    .irq       (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s got %h want %h", nm, act, exp);
    end
  endtask

  task automatic sample(output logic t, output logic q,
                        output logic [31:0] st);
    mem_re   = 1'b1;
    mem_addr = 4'h4;
    #1;
    t  = tx;
    q  = irq;
    st = mem_rdata;
    mem_re = 1'b0;
  endtask

  task automatic bus_write(input logic [3:0] a, input logic [31:0] d);
    @(negedge clk);
    mem_we    = 1'b1;
    mem_addr  = a;
    mem_wdata = d;
    @(negedge clk);
    mem_we = 1'b0;
  endtask

  task automatic bus_read(input logic [3:0] a, output logic [31:0] d);
    @(negedge clk);
    mem_re   = 1'b1;
    mem_addr = a;
    #1;
    d = mem_rdata;
    mem_re = 1'b0;
  endtask

  task automatic run_frames(input int n, input logic [7:0] b0,
                            input logic [7:0] b1, input int div,
                            input bit pre_wait, input string nm);
    logic        t;
    logic        q;
    logic [31:0] st;
    logic [7:0]  b;
    logic        etx;
    logic [31:0] est;
    int          fb;
    int          fr;
    int          pos;
    for (int k = 0; k < 10 * n * div; k++) begin
      if (k > 0 || pre_wait) @(negedge clk);
      sample(t, q, st);
      fb  = k / div;
      fr  = fb / 10;
      pos = fb % 10;
      b   = (fr == 0) ? b0 : b1;
      if (pos == 0)      etx = 1'b0;
      else if (pos == 9) etx = 1'b1;
      else               etx = b[pos-1];
      est = (fr < n - 1) ? 32'h11 : 32'h05;
      check($sformatf("%s_k%0d", nm, k), {30'd0, t, q, st},
            {30'd0, etx, 1'b0, est});
    end
    @(negedge clk);
    sample(t, q, st);
    check($sformatf("%s_end", nm), {30'd0, t, q, st},
          {30'd0, 1'b1, 1'b1, 32'h04});
  endtask

  initial begin
    logic        t;
    logic        q;
    logic [31:0] st;
    logic [31:0] rd;
    logic        bad;

    n_checks  = 0;
    n_err     = 0;
    rst_n     = 1'b0;
    mem_we    = 1'b0;
    mem_re    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;

    tbl[0]  = '{1'b0, 1'b1, 4'h4, 32'h0, 32'h4, "rst_status"};
    tbl[1]  = '{1'b0, 1'b1, 4'h8, 32'h0, 32'd868, "rst_div"};
    tbl[2]  = '{1'b0, 1'b1, 4'h0, 32'h0, 32'h0, "txdata_rd"};
    tbl[3]  = '{1'b0, 1'b1, 4'hC, 32'h0, 32'h0, "regc_rd"};
    tbl[4]  = '{1'b0, 1'b0, 4'h8, 32'h0, 32'h0, "re_gate"};
    tbl[5]  = '{1'b1, 1'b0, 4'h8, 32'h0, 32'h0, "div0_wr"};
    tbl[6]  = '{1'b0, 1'b1, 4'h8, 32'h0, 32'h1, "div0_rd"};
    tbl[7]  = '{1'b1, 1'b0, 4'hC, 32'hFFFF_FFFF, 32'h0, "regc_wr"};
    tbl[8]  = '{1'b0, 1'b1, 4'hA, 32'h0, 32'h1, "div_lowbits"};
    tbl[9]  = '{1'b1, 1'b0, 4'h8, 32'h0001_2345, 32'h0, "div_wr"};
    tbl[10] = '{1'b0, 1'b1, 4'h8, 32'h0, 32'h2345, "div_trunc"};
    tbl[11] = '{1'b1, 1'b0, 4'h4, 32'hFF, 32'h0, "status_wr"};
    tbl[12] = '{1'b0, 1'b1, 4'h4, 32'h0, 32'h4, "status_ro"};
    tbl[13] = '{1'b1, 1'b0, 4'h8, 32'h4, 32'h0, "div4_wr"};
    tbl[14] = '{1'b0, 1'b1, 4'h8, 32'h0, 32'h4, "div4_rd"};

    repeat (3) @(negedge clk);
    sample(t, q, st);
    check("reset_pins", {62'd0, t, q}, {62'd0, 2'b11});
    #1 rst_n = 1'b1;

    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      mem_we    = tbl[i].we;
      mem_re    = tbl[i].re;
      mem_addr  = tbl[i].addr;
      mem_wdata = tbl[i].wdata;
      #1;
      check(tbl[i].name, {32'd0, mem_rdata}, {32'd0, tbl[i].exp});
    end
    @(negedge clk);
    mem_we = 1'b0;
    mem_re = 1'b0;

    bus_write(4'h0, 32'h55);
    sample(t, q, st);
    check("single_pre", {30'd0, t, q, st}, {30'd0, 1'b1, 1'b0, 32'h10});
    run_frames(1, 8'h55, 8'h00, 4, 1'b1, "single");

    bus_write(4'h8, 32'h0);
    bus_read(4'h8, rd);
    check("div0_again", {32'd0, rd}, {32'd0, 32'h1});
    bus_write(4'h0, 32'hFF);
    run_frames(1, 8'hFF, 8'h00, 1, 1'b1, "div1");

    bus_write(4'h8, 32'h2);
    @(negedge clk);
    mem_we    = 1'b1;
    mem_addr  = 4'h0;
    mem_wdata = 32'hA5;
    @(negedge clk);
    mem_wdata = 32'h3C;
    @(negedge clk);
    mem_we = 1'b0;
    run_frames(2, 8'hA5, 8'h3C, 2, 1'b0, "b2b");

    bus_write(4'h8, 32'h4);
    @(negedge clk);
    mem_we    = 1'b1;
    mem_addr  = 4'h0;
    mem_wdata = 32'h00;
    @(negedge clk);
    @(negedge clk);
    mem_we = 1'b0;
    repeat (6) @(negedge clk);
    sample(t, q, st);
    check("mid_pre", {30'd0, t, q, st}, {30'd0, 1'b0, 1'b0, 32'h11});
    #2 rst_n = 1'b0;
    #1;
    check("async_rst", {62'd0, tx, irq}, {62'd0, 2'b11});
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    sample(t, q, st);
    check("post_rst", {30'd0, t, q, st}, {30'd0, 1'b1, 1'b1, 32'h04});
    bus_read(4'h8, rd);
    check("post_rst_div", {32'd0, rd}, {32'd0, 32'd868});
    bad = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (tx !== 1'b1 || irq !== 1'b1) bad = 1'b1;
    end
    check("no_frame", {63'd0, bad}, 64'd0);

    bus_write(4'h8, 32'd1000);
    @(negedge clk);
    mem_we   = 1'b1;
    mem_addr = 4'h0;
    for (int i = 0; i < 10; i++) begin
      mem_wdata = 32'(i);
      @(negedge clk);
    end
    mem_we = 1'b0;
    sample(t, q, st);
    check("ovf_set", {30'd0, t, q, st}, {30'd0, 1'b0, 1'b0, 32'h8B});
    bus_write(4'h4, 32'h8);
    sample(t, q, st);
    check("ovf_clr", {32'd0, st}, {32'd0, 32'h83});

    #2 rst_n = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule
